// File: rtl/datapath_acc.sv
// Frame accumulator: sums LEN signed datapath results, counts carry-outs,
// and presents one saturated N-bit result per frame over valid/ready.
module datapath_acc #(
  parameter int N     = 16,
  parameter int ACC_W = 24,
  parameter int LEN   = 8,
  localparam int CW   = $clog2(LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_y,
  input  logic          in_co,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_acc,
  output logic          out_sat,
  output logic [CW-1:0] out_co_cnt
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  // Clamp limits of an N-bit signed result, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  logic [0:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic [CW-1:0]           co_cnt;

  logic signed [N-1:0]     y_s;
  logic signed [ACC_W-1:0] sum_next;
  logic [CW-1:0]           co_next;
  logic                    last_beat;
  logic [N-1:0]            sat_val;
  logic                    sat_flag;

  // Returns {clamped flag, N-bit value} for a full-width frame sum.
  function automatic logic [N:0] saturate(input logic signed [ACC_W-1:0] s);
    logic [N:0] r;
    if (s > MAX_V)
      r = {1'b1, 1'b0, {(N-1){1'b1}}};
    else if (s < MIN_V)
      r = {1'b1, 1'b1, {(N-1){1'b0}}};
    else
      r = {1'b0, s[N-1:0]};
    return r;
  endfunction

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_DONE);
  assign y_s       = in_y;
  assign last_beat = (cnt == CNT_W'(LEN - 1));

  // Next sum, next carry count and the saturated view of the next sum.
  always_comb begin
    sum_next            = acc + ACC_W'(y_s);
    co_next             = co_cnt + CW'(in_co);
    {sat_flag, sat_val} = saturate(sum_next);
  end

  // Frame state machine: accumulate LEN accepts, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ACC;
      acc        <= '0;
      cnt        <= '0;
      co_cnt     <= '0;
      out_acc    <= '0;
      out_sat    <= 1'b0;
      out_co_cnt <= '0;
    end else if (clear) begin
      // Abort wins over any accept or output handshake in this cycle.
      state  <= ST_ACC;
      acc    <= '0;
      cnt    <= '0;
      co_cnt <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            acc    <= sum_next;
            cnt    <= cnt + CNT_W'(1);
            co_cnt <= co_next;
            if (last_beat) begin
              state      <= ST_DONE;
              out_acc    <= sat_val;
              out_sat    <= sat_flag;
              out_co_cnt <= co_next;
            end
          end
        end
        default: begin
          // Result registers keep their values after the handshake.
          if (out_ready) begin
            state  <= ST_ACC;
            acc    <= '0;
            cnt    <= '0;
            co_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_acc.sv
// Directed self-checking bench for datapath_acc (N=16, ACC_W=24, LEN=8).
module tb_datapath_acc;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_y;
  logic        in_co;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_acc;
  logic        out_sat;
  logic [3:0]  out_co_cnt;

  int checks = 0;
  int errors = 0;

  datapath_acc #(.N(16), .ACC_W(24), .LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_co(in_co),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_sat(out_sat), .out_co_cnt(out_co_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input beat, presented for exactly one clock edge.
  task automatic send(input logic [15:0] y, input logic co);
    in_valid = 1'b1;
    in_y     = y;
    in_co    = co;
    tick();
    in_valid = 1'b0;
    in_co    = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [15:0] y);
    for (int i = 0; i < n; i++) send(y, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_y = '0; in_co = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready",  in_ready,   1);
    chk("rst_out_valid", out_valid,  0);
    chk("rst_out_acc",   out_acc,    0);
    chk("rst_out_sat",   out_sat,    0);
    chk("rst_co_cnt",    out_co_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Frame 1..8, carries on inputs 2,4,7.
    for (int i = 1; i <= 8; i++)
      send(16'(i), (i == 2) || (i == 4) || (i == 7));
    chk("f1_out_valid", out_valid,  1);
    chk("f1_in_ready",  in_ready,   0);
    chk("f1_out_acc",   out_acc,    36);
    chk("f1_out_sat",   out_sat,    0);
    chk("f1_co_cnt",    out_co_cnt, 3);
    tick();
    chk("f1_ready_back", in_ready,  1);
    chk("f1_valid_drop", out_valid, 0);
    chk("f1_acc_kept",   out_acc,   36);

    // Positive saturation.
    send_n(8, 16'h7000);
    chk("pos_out_acc", out_acc, 16'h7FFF);
    chk("pos_out_sat", out_sat, 1);
    tick();

    // Negative saturation.
    send_n(8, 16'h8000);
    chk("neg_out_acc", out_acc, 16'h8000);
    chk("neg_out_sat", out_sat, 1);
    chk("neg_co_cnt",  out_co_cnt, 0);
    tick();

    // Mixed signs +100/-300 x4.
    for (int i = 0; i < 4; i++) begin
      send(16'd100, 1'b0);
      send(16'hFED4, 1'b0);
    end
    chk("mix_out_acc", out_acc, 16'hFCE0);
    chk("mix_out_sat", out_sat, 0);
    tick();

    // Backpressure: result held while in_valid stays high.
    out_ready = 1'b0;
    send_n(8, 16'd3);
    in_valid = 1'b1;
    in_y     = 16'd5;
    in_co    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid,  1);
      chk("bp_out_acc",   out_acc,    24);
      chk("bp_in_ready",  in_ready,   0);
      chk("bp_co_cnt",    out_co_cnt, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_co    = 1'b0;
    chk("bp_hs_ready", in_ready,  1);
    chk("bp_hs_valid", out_valid, 0);
    send_n(8, 16'd2);
    chk("bp_next_acc",   out_acc,    16);
    chk("bp_next_co",    out_co_cnt, 0);
    tick();

    // Clear after 3 accepts; the accept in the clear cycle is dropped.
    send_n(3, 16'd7);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_y     = 16'd100;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_in_ready",  in_ready,  1);
    chk("clr_out_valid", out_valid, 0);
    send_n(7, 16'd2);
    chk("clr_not_done",  out_valid, 0);
    send(16'd2, 1'b0);
    chk("clr_out_valid2", out_valid, 1);
    chk("clr_out_acc",    out_acc,   16);
    tick();

    // Asynchronous reset while in DONE.
    out_ready = 1'b0;
    send_n(8, 16'd4);
    chk("rd_out_valid", out_valid, 1);
    chk("rd_out_acc",   out_acc,   32);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rd_async_valid", out_valid, 0);
    chk("rd_async_ready", in_ready,  1);
    chk("rd_async_acc",   out_acc,   0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("rd_post_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_acc.md
# datapath_acc

Frame accumulator that sits directly downstream of the arithmetic datapath and consumes its `Y`/`co` results. It sums LEN signed datapath results into a wide accumulator, counts carry-outs, then presents one saturated N-bit result per frame over a valid/ready handshake. It provides the neuron-style sum-of-products reduction stage that the next block in the accelerator consumes.

## Interface
- `N`, 16: width of datapath result and of `out_acc`.
- `ACC_W`, 24: internal accumulator width. Must satisfy ACC_W >= N + clog2(LEN) so the frame sum never wraps.
- `LEN`, 8: results per frame, LEN >= 1.
- Localparam `CW` = $clog2(LEN+1): width of carry counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous frame abort.
- `in_valid`  in  1  `in_y`/`in_co` valid.
- `in_ready`  out  1  block accepts input this cycle.
- `in_y`  in  N  signed datapath result (`Y`).
- `in_co`  in  1  datapath carry-out (`co`).
- `out_valid`  out  1  frame result available.
- `out_ready`  in  1  downstream accepts result.
- `out_acc`  out  N  signed saturated frame sum.
- `out_sat`  out  1  `out_acc` was clamped.
- `out_co_cnt`  out  CW  number of accepted inputs with `in_co`=1 in the frame.

## Operation
- Two states: ACC and DONE. `in_ready` = (state==ACC). `out_valid` = (state==DONE), registered.
- Accept = `in_valid` && `in_ready`. On accept in ACC:
  - acc <= acc + sign-extend(`in_y`) to ACC_W.
  - cnt <= cnt+1.
  - co_cnt <= co_cnt + `in_co`.
- Last accept, when cnt == LEN-1:
  - Go to DONE.
  - Load `out_acc`, `out_sat`, `out_co_cnt` from the new sum S and new co_cnt in the same edge.
- Saturation of S:
  - S > 2^(N-1)-1: `out_acc`=0x7FFF (for N=16), `out_sat`=1.
  - S < -2^(N-1): `out_acc`=0x8000, `out_sat`=1.
  - Otherwise `out_acc`=S[N-1:0], `out_sat`=0.
- DONE:
  - Outputs are held stable. `in_valid` is ignored and no input is accepted.
  - On `out_ready`=1: acc, cnt and co_cnt go to 0 and the state returns to ACC. `out_acc`/`out_sat`/`out_co_cnt` keep their last values. Only `out_valid` drops.
- `clear`=1 (any state):
  - Next edge: acc, cnt and co_cnt go to 0, state goes to ACC, `out_valid` goes to 0.
  - Any accept or output handshake in that cycle is discarded.
  - `clear` has priority over everything except `rst_n`.
- LEN=1: every accept goes directly to DONE.
- co_cnt is only a count; the carry has no effect on the sum.

## Timing
- Reset (`rst_n`=0, immediate, asynchronous):
  - State ACC, so `in_ready`=1.
  - acc, cnt, co_cnt = 0.
  - `out_valid`=0, `out_acc`=0, `out_sat`=0, `out_co_cnt`=0.
- Latency: `out_valid` rises on the edge of the LEN-th accept and is visible the following cycle.
- Handshake:
  - Output transfers on the edge where `out_valid`&&`out_ready`.
  - `in_ready` returns to 1 the cycle after that edge.
- Throughput: at most one frame per LEN+1 cycles. Input and output never overlap.
- `out_valid` must never drop without a handshake, `clear`, or reset.
- Reset asserted mid-frame or in DONE: partial sum is lost and no output is produced.
- Deasserting `rst_n` has no combinational effect on outputs.

## Test plan
- Reset, LEN=8, inputs 1..8 back-to-back, `in_co`=1 on inputs 2,4,7, `out_ready`=1:
  - `out_valid`=1 one cycle after the 8th accept.
  - `out_acc`=36, `out_sat`=0, `out_co_cnt`=3.
  - `in_ready`=1 again the next cycle.
- Positive saturation, 8 × 0x7000 (sum 229376): `out_acc`=0x7FFF, `out_sat`=1.
- Negative saturation, 8 × 0x8000 (sum -262144): `out_acc`=0x8000, `out_sat`=1.
- Mixed signs, inputs +100,-300 alternating ×4: `out_acc`=0xFCE0 (-800), `out_sat`=0.
- Backpressure, `out_ready`=0 for 5 cycles with `in_valid`=1 throughout:
  - `out_valid` and `out_acc` stable, `in_ready`=0, no input consumed.
  - After the handshake, the next frame of 8 × 2 gives `out_acc`=16.
- `clear` after 3 accepts, then 8 × 2: `out_acc`=16.
- `rst_n` pulsed low while in DONE:
  - `out_valid`=0 and `in_ready`=1 without waiting for a clock edge.
  - `out_acc`=0.
